// File: rtl/btn_accumulator.sv
// Debounced weighted-step accumulator: sums simultaneous step presses, counts up/down, wraps or saturates.
// Optional sticky range flag built only when BTN_ACC_OVF_EN is defined; otherwise ovf is tied low.

module debounce #(
  parameter int CLK_HZ      = 25_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic i_clk,
  input  logic i_btn,
  output logic o_pressed
);
  localparam int CNT_RAW = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int CNT     = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int CW      = $clog2(CNT + 1);

  logic          w_raw;
  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_pressed;

  assign w_raw = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

  // Unreset by design: any power-up state converges once the input has been stable for CNT cycles.
  always_ff @(posedge i_clk) begin
    r_sync    <= {r_sync[0], w_raw};
    r_pressed <= 1'b0;
    if (r_sync[1] == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt >= CW'(CNT - 1)) begin
      r_stable  <= r_sync[1];
      r_cnt     <= '0;
      r_pressed <= r_sync[1];
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_pressed = r_pressed;
endmodule

module btn_accumulator #(
  parameter int CLK_HZ      = 25_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int ACTIVE_LOW  = 0,
  parameter int NUM_STEP    = 3,
  parameter int WIDTH       = 8,
  parameter int SATURATE    = 0
) (
  input  logic                  clk_25mhz,
  input  logic                  rst,
  input  logic [NUM_STEP+1:0]   btn,
  output logic [WIDTH-1:0]      led,
  output logic                  dir,
  output logic                  upd,
  output logic                  ovf
);
  localparam int AW = WIDTH + 2;

  logic [NUM_STEP+1:0] w_p;
  logic [NUM_STEP-1:0] w_step;
  logic                w_tog;
  logic                w_clr;
  logic [AW-1:0]       w_s;
  logic [AW-1:0]       w_cur;
  logic [AW-1:0]       w_sum;
  logic                w_neg;
  logic                w_big;
  logic [WIDTH-1:0]    w_next;

  logic [WIDTH-1:0]    r_led;
  logic                r_dir;
  logic                r_upd;

  genvar k;
  generate
    for (k = 0; k < NUM_STEP + 2; k++) begin : g_db
      debounce #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_db (
        .i_clk     (clk_25mhz),
        .i_btn     (btn[k]),
        .o_pressed (w_p[k])
      );
    end
  endgenerate

  assign w_step = w_p[NUM_STEP-1:0];
  assign w_tog  = w_p[NUM_STEP];
  assign w_clr  = w_p[NUM_STEP+1];

  // Step i weighs 2^i, so the pulse vector read as a number is already the sum.
  assign w_s   = {{(AW-NUM_STEP){1'b0}}, w_step};
  assign w_cur = {2'b00, r_led};
  assign w_sum = r_dir ? (w_cur - w_s) : (w_cur + w_s);
  assign w_neg = w_sum[AW-1];
  assign w_big = ~w_sum[AW-1] & w_sum[WIDTH];

  always_comb begin
    w_next = w_sum[WIDTH-1:0];
    if (SATURATE != 0) begin
      if (w_neg)      w_next = '0;
      else if (w_big) w_next = '1;
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      r_led <= '0;
      r_dir <= 1'b0;
      r_upd <= 1'b0;
    end else begin
      if (w_clr)        r_led <= '0;
      else if (|w_step) r_led <= w_next;
      r_dir <= r_dir ^ w_tog;
      r_upd <= w_clr | w_tog | (|w_step);
    end
  end

`ifdef BTN_ACC_OVF_EN
  logic w_oor;
  logic r_ovf;

  // Steps are discarded on a clear cycle, so clear alone decides the flag then.
  assign w_oor = (|w_step) & (w_neg | w_big);

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst)        r_ovf <= 1'b0;
    else if (w_clr) r_ovf <= 1'b0;
    else if (w_oor) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign led = r_led;
  assign dir = r_dir;
  assign upd = r_upd;
endmodule

// File: tb/tb_btn_accumulator.sv
// Scoreboard bench: wrap and saturate accumulators share the buttons; a behavioural model predicts each update.
module tb_btn_accumulator;
`ifdef BTN_ACC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    int led;
    int dir;
    int ovf;
  } st_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;
  logic [3:0] led_w, led_s;
  logic       dir_w, dir_s, upd_w, upd_s, ovf_w, ovf_s;

  int  n_tests = 0;
  int  n_fail  = 0;
  st_t mw, ms;
  st_t q_w[$];
  st_t q_s[$];

  always #5 clk = ~clk;

  btn_accumulator #(.CLK_HZ(4000), .DEBOUNCE_MS(1), .ACTIVE_LOW(0), .NUM_STEP(3), .WIDTH(4), .SATURATE(0)) u_wrap (
    .clk_25mhz(clk), .rst(rst), .btn(btn), .led(led_w), .dir(dir_w), .upd(upd_w), .ovf(ovf_w));

  btn_accumulator #(.CLK_HZ(4000), .DEBOUNCE_MS(1), .ACTIVE_LOW(0), .NUM_STEP(3), .WIDTH(4), .SATURATE(1)) u_sat (
    .clk_25mhz(clk), .rst(rst), .btn(btn), .led(led_s), .dir(dir_s), .upd(upd_s), .ovf(ovf_s));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: one button event (mask bit 0..2 steps, 3 toggle, 4 clear) applied to a whole-number state.
  function automatic st_t apply(input st_t s, input int mask, input bit sat);
    int sum, t;
    st_t r;
    r   = s;
    sum = mask & 7;
    if (((mask >> 4) & 1) != 0) begin
      r.led = 0;
      r.ovf = 0;
    end else if (sum != 0) begin
      t = (s.dir != 0) ? s.led - sum : s.led + sum;
      if (t > 15 || t < 0) begin
        if (OVF_EN) r.ovf = 1;
        if (sat) r.led = (t > 15) ? 15 : 0;
        else     r.led = (t + 16) % 16;
      end else begin
        r.led = t;
      end
    end
    if (((mask >> 3) & 1) != 0) r.dir = 1 - s.dir;
    return r;
  endfunction

  task automatic press(input int mask);
    @(posedge clk); #1;
    btn = mask[4:0];
    if (!rst && mask != 0) begin
      mw = apply(mw, mask, 1'b0);
      ms = apply(ms, mask, 1'b1);
      q_w.push_back(mw);
      q_s.push_back(ms);
    end
    repeat (12) @(posedge clk);
    #1 btn = '0;
    repeat (12) @(posedge clk);
    #1;
    chk("pending_wrap", q_w.size(), 0);
    chk("pending_sat", q_s.size(), 0);
  endtask

  task automatic goto_val(input int v);
    int rem;
    press(16);
    if (mw.dir != 0) press(8);
    rem = v;
    while (rem > 0) begin
      press(rem > 7 ? 7 : rem);
      rem = rem - (rem > 7 ? 7 : rem);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && upd_w) begin
      if (q_w.size() == 0) chk("spurious_upd_wrap", 1, 0);
      else begin
        st_t e;
        e = q_w.pop_front();
        chk("led_wrap", int'(led_w), e.led);
        chk("dir_wrap", int'(dir_w), e.dir);
        chk("ovf_wrap", int'(ovf_w), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && upd_s) begin
      if (q_s.size() == 0) chk("spurious_upd_sat", 1, 0);
      else begin
        st_t e;
        e = q_s.pop_front();
        chk("led_sat", int'(led_s), e.led);
        chk("dir_sat", int'(dir_s), e.dir);
        chk("ovf_sat", int'(ovf_s), e.ovf);
      end
    end
  end

  initial begin
    mw = '{0, 0, 0};
    ms = '{0, 0, 0};
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_led", int'(led_w), 0);
    chk("rst_dir", int'(dir_w), 0);
    chk("rst_ovf", int'(ovf_w), 0);
    chk("rst_upd", int'(upd_w), 0);

    // Two steps landing together add their weights.
    goto_val(3);
    press(5);
    chk("sum_led", int'(led_w), 8);

    // Overflow: wrap versus clamp, flag sticky.
    goto_val(14);
    press(4);
    chk("wrap_led", int'(led_w), 2);
    chk("sat_led", int'(led_s), 15);
    chk("wrap_ovf", int'(ovf_w), int'(OVF_EN));
    press(1);
    chk("wrap_led2", int'(led_w), 3);
    chk("wrap_ovf_hold", int'(ovf_w), int'(OVF_EN));

    // Underflow clamps to zero when counting down.
    goto_val(3);
    press(8);
    press(4);
    chk("sat_under", int'(led_s), 0);
    chk("wrap_under", int'(led_w), 15);

    // Clear wins over a same-cycle step; step plus toggle uses the old direction.
    goto_val(5);
    press(2 | 16);
    chk("clr_led", int'(led_w), 0);
    chk("clr_ovf", int'(ovf_w), 0);
    goto_val(5);
    press(1 | 8);
    chk("tog_led", int'(led_w), 6);
    chk("tog_dir", int'(dir_w), 1);

    // Asynchronous reset mid-count; pulses during reset are ignored.
    goto_val(9);
    chk("pre_rst_led", int'(led_w), 9);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_led", int'(led_w), 0);
    chk("arst_dir", int'(dir_w), 0);
    chk("arst_ovf", int'(ovf_s), 0);
    chk("arst_upd", int'(upd_w), 0);
    press(1);
    chk("rst_hold_led", int'(led_w), 0);
    chk("rst_hold_sat", int'(led_s), 0);
    mw = '{0, 0, 0};
    ms = '{0, 0, 0};
    q_w.delete();
    q_s.delete();
    @(posedge clk); #1 rst = 1'b0;

    // Random mixes of steps, toggles and occasional clears.
    for (int i = 0; i < 120; i++) begin
      int m;
      m = int'($urandom_range(0, 31));
      if ($urandom_range(0, 5) != 0) m = m & 15;
      if (((m >> 4) & 1) != 0) m = m & 23;
      press(m);
    end
    chk("final_led_wrap", int'(led_w), mw.led);
    chk("final_led_sat", int'(led_s), ms.led);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
